// File: rtl/gray_decoder_monitor_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_decoder_monitor_if : control/Gray-bus bundle for the monitor |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface gray_decoder_monitor_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
);
  logic             enable;
  logic             clear_err_i;
  logic [WIDTH-1:0] gray_i;
  logic [WIDTH-1:0] binario_o;
  logic             valido_o;
  logic             dir_o;
  logic             error_o;
  logic [ERR_W-1:0] cuenta_err_o;
  logic [6:0]       segmentos_o;

  modport master (
    output enable, clear_err_i, gray_i,
    input  binario_o, valido_o, dir_o, error_o, cuenta_err_o, segmentos_o
  );

  modport slave (
    input  enable, clear_err_i, gray_i,
    output binario_o, valido_o, dir_o, error_o, cuenta_err_o, segmentos_o
  );
endinterface
`default_nettype wire

// File: rtl/gray_decoder_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gray_decoder_monitor : syncs a Gray bus, decodes, checks steps    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module gray_decoder_monitor #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  gray_decoder_monitor_if.slave   bus
);

  localparam logic [1:0] ARRANQUE    = 2'd0;
  localparam logic [1:0] SEGUIMIENTO = 2'd1;
  localparam logic [1:0] FALLA       = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] binario;
  logic             valido;
  logic             dir;
  logic             error_flag;
  logic [ERR_W-1:0] err_count;

  logic [WIDTH-1:0] bin_now;
  logic [WIDTH-1:0] diff;
  logic             diff_any;
  logic             diff_multi;
  logic             step_up;
  logic             err_sat;
  logic [6:0]       seg;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_now = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_now[i] = ^(sync2 >> i);
    end
  end

  always_comb begin
    diff       = sync2 ^ prev_gray;
    diff_any   = |diff;
    diff_multi = |(diff & (diff - WIDTH'(1)));
    step_up    = (bin_now == (binario + WIDTH'(1)));
    err_sat    = &err_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      prev_gray  <= '0;
      binario    <= '0;
      valido     <= 1'b0;
      dir        <= 1'b1;
      error_flag <= 1'b0;
      err_count  <= '0;
      state      <= ARRANQUE;
    end else begin
      sync1  <= bus.gray_i;
      sync2  <= sync1;
      valido <= 1'b0;

      // Clearing wins over any step check and re-baselines on the next enabled cycle.
      if (bus.clear_err_i) begin
        error_flag <= 1'b0;
        state      <= ARRANQUE;
      end else if (bus.enable) begin
        case (state)
          ARRANQUE: begin
            prev_gray <= sync2;
            binario   <= bin_now;
            state     <= SEGUIMIENTO;
          end

          SEGUIMIENTO: begin
            if (diff_any && !diff_multi) begin
              prev_gray <= sync2;
              binario   <= bin_now;
              valido    <= 1'b1;
              dir       <= step_up;
            end else if (diff_multi) begin
              prev_gray  <= sync2;
              binario    <= bin_now;
              error_flag <= 1'b1;
              if (!err_sat) begin
                err_count <= err_count + ERR_W'(1);
              end
              state <= FALLA;
            end
          end

          FALLA: begin
            if (diff_any) begin
              prev_gray <= sync2;
              binario   <= bin_now;
            end
            if (diff_multi && !err_sat) begin
              err_count <= err_count + ERR_W'(1);
            end
          end

          default: begin
            state <= ARRANQUE;
          end
        endcase
      end
    end
  end

  // Active-low abcdefg; codes above 9 blank the digit.
  always_comb begin
    seg = 7'b1111111;
    case (binario[3:0])
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

  assign bus.binario_o    = binario;
  assign bus.valido_o     = valido;
  assign bus.dir_o        = dir;
  assign bus.error_o      = error_flag;
  assign bus.cuenta_err_o = err_count;
  assign bus.segmentos_o  = seg;

endmodule
`default_nettype wire

// File: tb/tb_gray_decoder_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gray_decoder_monitor : directed bench, WIDTH=4, ERR_W=8 and 2  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_gray_decoder_monitor;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   total;
  int   bad;
  logic [6:0] seg_tab [16];

  gray_decoder_monitor_if #(.WIDTH(4), .ERR_W(8)) bus_a ();
  gray_decoder_monitor_if #(.WIDTH(4), .ERR_W(2)) bus_b ();

  gray_decoder_monitor #(.WIDTH(4), .ERR_W(8)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  gray_decoder_monitor #(.WIDTH(4), .ERR_W(2)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Apply a Gray value, verify nothing shows for two edges, then the result on the third.
  task automatic do_step(input logic [3:0] g, input logic [3:0] eb, input logic ed,
                         input logic ev, input string tag);
    bus_a.gray_i = g;
    step();
    check({tag, "_v_e1"}, 32'(bus_a.valido_o), 32'(0));
    step();
    check({tag, "_v_e2"}, 32'(bus_a.valido_o), 32'(0));
    step();
    check({tag, "_v"},   32'(bus_a.valido_o),    32'(ev));
    check({tag, "_bin"}, 32'(bus_a.binario_o),   32'(eb));
    check({tag, "_dir"}, 32'(bus_a.dir_o),       32'(ed));
    check({tag, "_seg"}, 32'(bus_a.segmentos_o), 32'(seg_tab[eb]));
    step();
    check({tag, "_v_off"}, 32'(bus_a.valido_o), 32'(0));
    step();
  endtask

  initial begin
    logic [3:0] g;
    logic [1:0] exp_cnt;
    total = 0;
    bad   = 0;
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1111111;

    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.enable = 1'b0; bus_a.clear_err_i = 1'b0; bus_a.gray_i = 4'b0000;
    bus_b.enable = 1'b0; bus_b.clear_err_i = 1'b0; bus_b.gray_i = 4'b0000;
    step(); step(); step();

    check("rst_bin",  32'(bus_a.binario_o),    32'(0));
    check("rst_v",    32'(bus_a.valido_o),     32'(0));
    check("rst_dir",  32'(bus_a.dir_o),        32'(1));
    check("rst_err",  32'(bus_a.error_o),      32'(0));
    check("rst_cnt",  32'(bus_a.cuenta_err_o), 32'(0));
    check("rst_seg",  32'(bus_a.segmentos_o),  32'(7'b0000001));

    reset_a = 1'b0;
    bus_a.enable = 1'b1;
    step(); step(); step(); step();
    check("base_bin", 32'(bus_a.binario_o),   32'(0));
    check("base_v",   32'(bus_a.valido_o),    32'(0));
    check("base_seg", 32'(bus_a.segmentos_o), 32'(7'b0000001));
    check("base_err", 32'(bus_a.error_o),     32'(0));

    do_step(4'b0001, 4'd1, 1'b1, 1'b1, "up1");
    do_step(4'b0011, 4'd2, 1'b1, 1'b1, "up2");
    do_step(4'b0010, 4'd3, 1'b1, 1'b1, "up3");
    do_step(4'b0110, 4'd4, 1'b1, 1'b1, "up4");

    // Climb to 15 (Gray 1000) one legal step at a time.
    for (int n = 5; n < 16; n++) begin
      g = 4'(n) ^ (4'(n) >> 1);
      do_step(g, 4'(n), 1'b1, 1'b1, "climb");
    end

    do_step(4'b0000, 4'd0,  1'b1, 1'b1, "wrap_up");
    do_step(4'b1000, 4'd15, 1'b0, 1'b1, "wrap_dn");
    do_step(4'b0000, 4'd0,  1'b1, 1'b1, "ret0");
    do_step(4'b0001, 4'd1,  1'b1, 1'b1, "ret1");

    do_step(4'b0110, 4'd4, 1'b1, 1'b0, "jump");
    check("jump_err", 32'(bus_a.error_o),      32'(1));
    check("jump_cnt", 32'(bus_a.cuenta_err_o), 32'(1));
    do_step(4'b0111, 4'd5, 1'b1, 1'b0, "falla_step");
    check("falla_err", 32'(bus_a.error_o), 32'(1));

    bus_a.clear_err_i = 1'b1;
    step();
    bus_a.clear_err_i = 1'b0;
    check("clr_err", 32'(bus_a.error_o),      32'(0));
    check("clr_cnt", 32'(bus_a.cuenta_err_o), 32'(1));
    step();
    check("clr_base_v",   32'(bus_a.valido_o),  32'(0));
    check("clr_base_bin", 32'(bus_a.binario_o), 32'(5));
    do_step(4'b0101, 4'd6, 1'b1, 1'b1, "post_clr");
    check("post_clr_cnt", 32'(bus_a.cuenta_err_o), 32'(1));

    // Single-bit Gray change 6 -> 1 is legal but not an increment.
    do_step(4'b0001, 4'd1, 1'b0, 1'b1, "dn_leap");

    bus_a.enable = 1'b0;
    bus_a.gray_i = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      step();
      check("dis_v",   32'(bus_a.valido_o),  32'(0));
      check("dis_bin", 32'(bus_a.binario_o), 32'(1));
    end
    bus_a.enable = 1'b1;
    step();
    check("en_v",   32'(bus_a.valido_o),  32'(1));
    check("en_bin", 32'(bus_a.binario_o), 32'(2));
    check("en_dir", 32'(bus_a.dir_o),     32'(1));
    step();
    check("en_v_off", 32'(bus_a.valido_o), 32'(0));

    // Saturating counter on the 2-bit instance.
    reset_b = 1'b0;
    bus_b.enable = 1'b1;
    step(); step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      bus_b.gray_i = (k % 2 == 0) ? 4'b0011 : 4'b0000;
      step(); step(); step(); step();
      exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      check("sat_cnt", 32'(bus_b.cuenta_err_o), 32'(exp_cnt));
      check("sat_err", 32'(bus_b.error_o),      32'(1));
      check("sat_v",   32'(bus_b.valido_o),     32'(0));
    end
    check("sat_bin", 32'(bus_b.binario_o), 32'(2));

    bus_b.gray_i = 4'b0000;
    reset_b = 1'b1;
    step();
    check("mrst_bin", 32'(bus_b.binario_o),    32'(0));
    check("mrst_v",   32'(bus_b.valido_o),     32'(0));
    check("mrst_dir", 32'(bus_b.dir_o),        32'(1));
    check("mrst_err", 32'(bus_b.error_o),      32'(0));
    check("mrst_cnt", 32'(bus_b.cuenta_err_o), 32'(0));
    check("mrst_seg", 32'(bus_b.segmentos_o),  32'(7'b0000001));
    reset_b = 1'b0;
    step(); step(); step(); step();
    check("mrst_after_v",   32'(bus_b.valido_o),     32'(0));
    check("mrst_after_err", 32'(bus_b.error_o),      32'(0));
    check("mrst_after_cnt", 32'(bus_b.cuenta_err_o), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_decoder_monitor.md
Name: gray_decoder_monitor

Overview:
- Receiving end of the Gray-coded count bus produced by the team's Gray counters.
- Synchronises an asynchronous Gray bus, converts it to binary and checks that every change is a legal single-bit step.
- Reports step direction, flags illegal multi-bit jumps, and drives the same 7-segment display format used elsewhere in the design.

Parameters:
- WIDTH, 8, width of the Gray input bus and the binary output (minimum 4).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, step tracking and checking are active.
- clear_err_i  input  1  one-cycle pulse; clears the sticky error and re-baselines.
- gray_i  input  WIDTH  Gray-coded count, asynchronous to clk.
- binario_o  output  WIDTH  registered binary value of the last accepted sample.
- valido_o  output  1  one-cycle pulse on each legal single-step change.
- dir_o  output  1  direction of the last legal step: 1 = up, 0 = down.
- error_o  output  1  sticky flag; set on an illegal jump.
- cuenta_err_o  output  ERR_W  saturating count of illegal jumps.
- segmentos_o  output  7  active-low segments abcdefg for binario_o[3:0].

Behaviour:
- Reset values:
  - sync stages = 0; binario_o = 0; valido_o = 0; dir_o = 1; error_o = 0; cuenta_err_o = 0.
  - State = ARRANQUE.
  - segmentos_o = 7'b0000001 (digit 0).
- Synchroniser:
  - Two flops, s1 <= gray_i and s2 <= s1, clocked every cycle regardless of enable.
  - Only s2 is used downstream.
- Conversion: combinational, bin[WIDTH-1] = s2[WIDTH-1]; bin[i] = bin[i+1] ^ s2[i].
- Change detection: diff = s2 XOR prev_gray, where prev_gray is the last accepted Gray sample.
  - Legal step: diff has exactly one bit set.
  - Illegal jump: diff has two or more bits set.
- Direction: up if bin == binario_o + 1 mod 2^WIDTH, otherwise down. Wrap from max to 0 is up; wrap from 0 to max is down.
- State machine (all transitions require enable = 1, except clear_err_i and reset):
  - ARRANQUE: on the next enabled cycle, load prev_gray = s2 and binario_o = bin. valido_o stays 0 and no check is made. Go to SEGUIMIENTO.
  - SEGUIMIENTO, diff = 0: hold.
  - SEGUIMIENTO, legal step: update prev_gray and binario_o, pulse valido_o = 1 for one cycle, update dir_o.
  - SEGUIMIENTO, illegal jump: set error_o = 1, increment cuenta_err_o (saturate at 2^ERR_W - 1), still load prev_gray and binario_o, keep valido_o = 0, keep dir_o unchanged, go to FALLA.
  - FALLA: keep following the input (binario_o tracks bin on any change). valido_o stays 0. Further illegal jumps still increment cuenta_err_o. error_o stays 1.
  - clear_err_i = 1, in any state: error_o <= 0 and go to ARRANQUE. cuenta_err_o is NOT cleared. This takes priority over a simultaneous step check in the same cycle.
- enable = 0: state, binario_o, dir_o, error_o and the counter all hold; valido_o = 0. The synchroniser keeps running. When enable returns, the next comparison uses the held prev_gray.
- Latency:
  - A gray_i change present before edge N appears on binario_o and valido_o after edge N+2 (three rising edges, counting edge N).
  - Example: gray_i changes just before edge 1; s1 updates at edge 1, s2 at edge 2, and binario_o/valido_o at edge 3.
- reset dominates everything, including clear_err_i. Reset in the middle of operation returns the block to ARRANQUE with all reset values and flushes the synchroniser.
- segmentos_o:
  - Combinational from binario_o[3:0]: 0->0000001, 1->1001111, 2->0010010, 3->0000110, 4->1001100, 5->0100100, 6->0100000, 7->0001111, 8->0000000, 9->0000100.
  - 10 to 15 -> 1111111 (display off).

Test Plan (WIDTH=4):
- Reset, then enable = 1 with gray_i = 0000 -> after baseline: binario_o = 0, valido_o = 0, segmentos_o = 0000001, error_o = 0.
- Drive the Gray sequence 0000, 0001, 0011, 0010, 0110, holding each value 5 cycles -> binario_o goes 1, 2, 3, 4, with one valido_o pulse per step, each three edges after the change; dir_o = 1; segmentos_o for 4 = 1001100.
- From gray 1000 (binary 15), drive 0000 -> binario_o = 0, valido_o pulses, dir_o = 1 (wrap up). Then drive 1000 back -> binario_o = 15, dir_o = 0, segmentos_o = 1111111.
- From gray 0001, jump to 0110 -> error_o = 1, cuenta_err_o = 1, valido_o stays 0, binario_o = 4. A further legal step gives no valido_o pulse. Pulse clear_err_i -> error_o = 0, baseline reloads, and the next legal step pulses valido_o; cuenta_err_o is still 1.
- enable = 0 while gray_i steps 0001 -> 0011 -> outputs hold. Raise enable with gray_i = 0011 -> one legal step, binario_o = 2.
- With ERR_W = 2, force 5 illegal jumps -> cuenta_err_o saturates at 3. Then assert reset mid-stream -> the next cycle shows all outputs at their reset values.
